// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'b00;
    localparam size_t SIZE_HALF = 2'b01;
    localparam size_t SIZE_WORD = 2'b11;

    typedef logic req_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side and memory-side bus interfaces
interface dmem_req_if #(
    parameter int MEM_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    import dmem_arb_pkg::*;

    logic                  req;
    logic                  we;
    logic                  lock;
    logic [MEM_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    size_t                 size;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, size, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, size, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if #(
    parameter int MEM_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    import dmem_arb_pkg::*;

    logic [MEM_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  re;
    size_t                 size;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output addr, wdata, we, re, size, input rdata);
    modport slave  (input addr, wdata, we, re, size, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - two-way round-robin one-hot grant picker
module rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  req_id_t            rr_last,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = elig;
        // On a tie the requester that did not win last time goes next.
        if (&elig) begin
            gnt           = '0;
            gnt[~rr_last] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory port between core and loader
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_req_if.slave   r0,
    dmem_req_if.slave   r1,
    dmem_mem_if.master  mem
);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ-1:0]    lock;
    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    gnt;
    logic [MEM_WIDTH-1:0]  addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata [NUM_REQ];
    size_t                 size  [NUM_REQ];
    logic                  gnt_any;
    req_id_t               gnt_id;

    req_id_t rr_last_q,    rr_last_d;
    logic    rd_pend_q,    rd_pend_d;
    req_id_t rd_owner_q,   rd_owner_d;
    logic    lock_act_q,   lock_act_d;
    req_id_t lock_owner_q, lock_owner_d;

    assign req   = {r1.req,   r0.req};
    assign we    = {r1.we,    r0.we};
    assign lock  = {r1.lock,  r0.lock};
    assign addr  = '{r0.addr,  r1.addr};
    assign wdata = '{r0.wdata, r1.wdata};
    assign size  = '{r0.size,  r1.size};

    // Registered lock state is used so a release never opens the port in the same cycle.
    assign elig[0] = req[0] && (!lock_act_q || (lock_owner_q == 1'b0));
    assign elig[1] = req[1] && (!lock_act_q || (lock_owner_q == 1'b1));

    rr_picker u_picker (
        .elig    (elig),
        .rr_last (rr_last_q),
        .gnt     (gnt)
    );

    assign gnt_any = |gnt;
    assign gnt_id  = gnt[1];
    assign r0.gnt  = gnt[0];
    assign r1.gnt  = gnt[1];

    always_comb begin
        mem.addr  = '0;
        mem.wdata = '0;
        mem.size  = '0;
        mem.we    = 1'b0;
        mem.re    = 1'b0;
        if (gnt_any) begin
            mem.addr  = addr[gnt_id];
            mem.wdata = wdata[gnt_id];
            mem.size  = size[gnt_id];
            mem.we    = we[gnt_id];
            mem.re    = !we[gnt_id];
        end
    end

    always_comb begin
        rr_last_d    = gnt_any ? gnt_id : rr_last_q;
        rd_pend_d    = gnt_any && !we[gnt_id];
        rd_owner_d   = gnt_any ? gnt_id : rd_owner_q;
        lock_act_d   = lock_act_q;
        lock_owner_d = lock_owner_q;
        if (lock_act_q && !lock[lock_owner_q]) begin
            lock_act_d = 1'b0;
        end
        if (gnt_any && lock[gnt_id]) begin
            lock_act_d   = 1'b1;
            lock_owner_d = gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q    <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            lock_act_q   <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            lock_act_q   <= lock_act_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    // Synchronous memory presents read data in the cycle after the grant; steer it to the issuer.
    assign r0.rvalid = rd_pend_q && (rd_owner_q == 1'b0);
    assign r1.rvalid = rd_pend_q && (rd_owner_q == 1'b1);
    assign r0.rdata  = r0.rvalid ? mem.rdata : '0;
    assign r1.rdata  = r1.rvalid ? mem.rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic rst;

    dmem_req_if #(.MEM_WIDTH(8), .DATA_WIDTH(32)) r0_if ();
    dmem_req_if #(.MEM_WIDTH(8), .DATA_WIDTH(32)) r1_if ();
    dmem_mem_if #(.MEM_WIDTH(8), .DATA_WIDTH(32)) m_if ();

    dmem_arbiter #(.MEM_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .r0  (r0_if),
        .r1  (r1_if),
        .mem (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_arr [64];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
            mem_arr[8'h04 >> 2] <= 32'h11223344;
            mem_arr[8'h08 >> 2] <= 32'h08080808;
            mem_arr[8'h0C >> 2] <= 32'h0C0C0C0C;
            mem_arr[8'h10 >> 2] <= 32'hDEADBEEF;
            m_if.rdata <= 32'h0;
        end else begin
            if (m_if.we) begin
                case (m_if.size)
                    SIZE_BYTE: mem_arr[m_if.addr[7:2]][8*m_if.addr[1:0] +: 8] <= m_if.wdata[7:0];
                    SIZE_HALF: mem_arr[m_if.addr[7:2]][16*m_if.addr[1] +: 16] <= m_if.wdata[15:0];
                    default:   mem_arr[m_if.addr[7:2]] <= m_if.wdata;
                endcase
            end
            if (m_if.re) m_if.rdata <= mem_arr[m_if.addr[7:2]];
        end
    end

    typedef struct {
        string       name;
        logic        rst_before;
        logic [1:0]  req, we, lock;
        logic [7:0]  a0;
        logic [31:0] w0;
        logic [1:0]  s0;
        logic [7:0]  a1;
        logic [31:0] w1;
        logic [1:0]  s1;
        logic [1:0]  e_gnt;
        logic        e_re, e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_size;
        logic [1:0]  e_rvalid;
        logic [31:0] e_rdata;
    } step_t;

    step_t steps[$];
    int    errors = 0;
    int    checks = 0;

    function automatic step_t mk(string n, logic rb, logic [1:0] rq, logic [1:0] w, logic [1:0] lk,
                                 logic [7:0] a0, logic [31:0] w0, logic [1:0] s0,
                                 logic [7:0] a1, logic [31:0] w1, logic [1:0] s1,
                                 logic [1:0] eg, logic ere, logic ewe, logic [7:0] ea,
                                 logic [31:0] ewd, logic [1:0] es, logic [1:0] erv, logic [31:0] erd);
        step_t s;
        s.name = n; s.rst_before = rb; s.req = rq; s.we = w; s.lock = lk;
        s.a0 = a0; s.w0 = w0; s.s0 = s0; s.a1 = a1; s.w1 = w1; s.s1 = s1;
        s.e_gnt = eg; s.e_re = ere; s.e_we = ewe; s.e_addr = ea; s.e_wdata = ewd;
        s.e_size = es; s.e_rvalid = erv; s.e_rdata = erd;
        return s;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        r0_if.req = 0; r0_if.we = 0; r0_if.lock = 0; r0_if.addr = 0; r0_if.wdata = 0; r0_if.size = 0;
        r1_if.req = 0; r1_if.we = 0; r1_if.lock = 0; r1_if.addr = 0; r1_if.wdata = 0; r1_if.size = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_step(step_t s);
        if (s.rst_before) do_reset();
        @(posedge clk);
        #1;
        r0_if.req = s.req[0]; r0_if.we = s.we[0]; r0_if.lock = s.lock[0];
        r0_if.addr = s.a0; r0_if.wdata = s.w0; r0_if.size = s.s0;
        r1_if.req = s.req[1]; r1_if.we = s.we[1]; r1_if.lock = s.lock[1];
        r1_if.addr = s.a1; r1_if.wdata = s.w1; r1_if.size = s.s1;
        @(negedge clk);
        chk({s.name, " gnt"},    {30'b0, r1_if.gnt, r0_if.gnt}, {30'b0, s.e_gnt});
        chk({s.name, " re"},     {31'b0, m_if.re},  {31'b0, s.e_re});
        chk({s.name, " we"},     {31'b0, m_if.we},  {31'b0, s.e_we});
        chk({s.name, " addr"},   {24'b0, m_if.addr}, {24'b0, s.e_addr});
        chk({s.name, " wdata"},  m_if.wdata, s.e_wdata);
        chk({s.name, " size"},   {30'b0, m_if.size}, {30'b0, s.e_size});
        chk({s.name, " rvalid"}, {30'b0, r1_if.rvalid, r0_if.rvalid}, {30'b0, s.e_rvalid});
        if (s.e_rvalid[0]) chk({s.name, " r0_rdata"}, r0_if.rdata, s.e_rdata);
        if (s.e_rvalid[1]) chk({s.name, " r1_rdata"}, r1_if.rdata, s.e_rdata);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        //                  name  rb req we  lk  a0     w0     s0  a1     w1     s1  gnt re we addr   wdata  sz  rv  rdata
        steps.push_back(mk("A0", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0));
        steps.push_back(mk("A1", 0, 1, 0, 0, 8'h10, 32'h0, 3, 8'h00, 32'h0, 0, 1, 1, 0, 8'h10, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("A2", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 32'hDEADBEEF));
        steps.push_back(mk("A3", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0));
        steps.push_back(mk("B0", 1, 3, 0, 0, 8'h08, 32'h0, 3, 8'h0C, 32'h0, 3, 1, 1, 0, 8'h08, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("B1", 0, 3, 0, 0, 8'h08, 32'h0, 3, 8'h0C, 32'h0, 3, 2, 1, 0, 8'h0C, 32'h0, 3, 1, 32'h08080808));
        steps.push_back(mk("B2", 0, 3, 0, 0, 8'h08, 32'h0, 3, 8'h0C, 32'h0, 3, 1, 1, 0, 8'h08, 32'h0, 3, 2, 32'h0C0C0C0C));
        steps.push_back(mk("B3", 0, 3, 0, 0, 8'h08, 32'h0, 3, 8'h0C, 32'h0, 3, 2, 1, 0, 8'h0C, 32'h0, 3, 1, 32'h08080808));
        steps.push_back(mk("B4", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 2, 32'h0C0C0C0C));
        steps.push_back(mk("C0", 0, 1, 0, 0, 8'h08, 32'h0, 3, 8'h00, 32'h0, 0, 1, 1, 0, 8'h08, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("C1", 0, 2, 0, 0, 8'h00, 32'h0, 0, 8'h0C, 32'h0, 3, 2, 1, 0, 8'h0C, 32'h0, 3, 1, 32'h08080808));
        steps.push_back(mk("C2", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 2, 32'h0C0C0C0C));
        steps.push_back(mk("D0", 0, 2, 2, 0, 8'h00, 32'h0, 0, 8'h20, 32'hAB, 0, 2, 0, 1, 8'h20, 32'hAB, 0, 0, 32'h0));
        steps.push_back(mk("D1", 0, 1, 0, 0, 8'h20, 32'h0, 3, 8'h00, 32'h0, 0, 1, 1, 0, 8'h20, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("D2", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 32'h000000AB));
        steps.push_back(mk("E0", 1, 3, 0, 1, 8'h04, 32'h0, 3, 8'h0C, 32'h0, 3, 1, 1, 0, 8'h04, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("E1", 0, 2, 0, 1, 8'h00, 32'h0, 0, 8'h0C, 32'h0, 3, 0, 0, 0, 8'h00, 32'h0, 0, 1, 32'h11223344));
        steps.push_back(mk("E2", 0, 3, 1, 1, 8'h04, 32'h55, 3, 8'h0C, 32'h0, 3, 1, 0, 1, 8'h04, 32'h55, 3, 0, 32'h0));
        steps.push_back(mk("E3", 0, 2, 0, 0, 8'h00, 32'h0, 0, 8'h0C, 32'h0, 3, 0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0));
        steps.push_back(mk("E4", 0, 2, 0, 0, 8'h00, 32'h0, 0, 8'h0C, 32'h0, 3, 2, 1, 0, 8'h0C, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("E5", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 2, 32'h0C0C0C0C));
        steps.push_back(mk("E6", 0, 1, 0, 0, 8'h04, 32'h0, 3, 8'h00, 32'h0, 0, 1, 1, 0, 8'h04, 32'h0, 3, 0, 32'h0));
        steps.push_back(mk("E7", 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 32'h00000055));

        foreach (steps[i]) run_step(steps[i]);

        // Asynchronous reset while a locked read is in flight.
        do_reset();
        @(posedge clk);
        #1;
        r0_if.req = 1; r0_if.we = 0; r0_if.lock = 1; r0_if.addr = 8'h10; r0_if.size = SIZE_WORD;
        @(negedge clk);
        chk("R0 r0_gnt", {31'b0, r0_if.gnt}, 32'd1);
        @(posedge clk);
        #1;
        r0_if.req = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("R1 r0_rvalid", {31'b0, r0_if.rvalid}, 32'd0);
        chk("R1 r1_rvalid", {31'b0, r1_if.rvalid}, 32'd0);
        chk("R1 r0_rdata", r0_if.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        r1_if.req = 1; r1_if.we = 0; r1_if.addr = 8'h0C; r1_if.size = SIZE_WORD;
        @(negedge clk);
        chk("R2 r1_gnt after reset", {31'b0, r1_if.gnt}, 32'd1);
        chk("R2 r0_rvalid", {31'b0, r0_if.rvalid}, 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        chk("R3 r1_rvalid", {31'b0, r1_if.rvalid}, 32'd1);
        do_reset();
        @(posedge clk);
        #1;
        r0_if.req = 1; r0_if.addr = 8'h08; r0_if.size = SIZE_WORD;
        r1_if.req = 1; r1_if.addr = 8'h0C; r1_if.size = SIZE_WORD;
        @(negedge clk);
        chk("R4 tie gnt", {30'b0, r1_if.gnt, r0_if.gnt}, 32'd1);
        drive_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (synchronous read, 1-cycle read latency, byte/half/word sized writes) between two requesters.
- Requester 0 is the core load/store path; requester 1 is the program/debug loader.
- Sits between the core's memory-access stage and the DataMemory instance.
- Provides round-robin arbitration, a valid/grant handshake, routing of read data back to the requester that issued the read, and an optional lock for atomic read-modify-write sequences.

Parameters:
- MEM_WIDTH, 8: data-memory byte-address width.
- DATA_WIDTH, 32: data bus width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rN_req  in  1  requester N (N=0,1) access request; held until granted.
- rN_we  in  1  1 = write, 0 = read.
- rN_lock  in  1  request or hold exclusive ownership.
- rN_addr  in  MEM_WIDTH  byte address.
- rN_wdata  in  DATA_WIDTH  write data.
- rN_size  in  2  size code: 00 byte, 01 half, 11 word.
- rN_gnt  out  1  access accepted this cycle (combinational).
- rN_rvalid  out  1  read data valid (registered).
- rN_rdata  out  DATA_WIDTH  read data, meaningful only while rN_rvalid=1.
- mem_addr  out  MEM_WIDTH  address to data memory.
- mem_wdata  out  DATA_WIDTH  write data to data memory.
- mem_we  out  1  data memory write enable.
- mem_re  out  1  data memory read enable.
- mem_size  out  2  size code to data memory.
- mem_rdata  in  DATA_WIDTH  data memory read data, valid 1 cycle after mem_re.

Behaviour:
- State registers: rr_last (last granted requester); rd_pend and rd_owner (the read in flight); lock_act and lock_owner.
- Reset values: rr_last=1, so requester 0 wins the first tie. rd_pend=0, lock_act=0, rN_rvalid=0, rN_rdata=0.
- Combinational outputs are 0 whenever no grant is given: rN_gnt, mem_we, mem_re, mem_addr, mem_wdata, mem_size.
- Eligibility: requester N is eligible when rN_req=1, and either lock_act=0 or lock_owner=N.
- Selection:
  - One eligible requester: it is granted.
  - Both eligible: the requester that is not rr_last is granted.
  - At most one rN_gnt is high per cycle.
- Issue (same cycle as grant): the granted requester's addr/wdata/size are driven on mem_*; mem_we=rN_we and mem_re=~rN_we.
- Updates on a granted cycle: rr_last becomes the granted requester. If the access is a read, rd_pend=1 and rd_owner=N; otherwise rd_pend=0.
- Read response:
  - In the cycle after a read grant, r[rd_owner]_rvalid=1 and r[rd_owner]_rdata=mem_rdata, as a pure pass-through captured into an output register.
  - Read latency is exactly 1 cycle from grant.
  - Writes produce no rvalid.
- Throughput: one grant every cycle is permitted; back-to-back reads to different requesters each return on the following cycle.
- Lock:
  - A granted access with rN_lock=1 sets lock_act=1 and lock_owner=N at the clock edge.
  - lock_act clears at the first edge where r[lock_owner]_lock=0. The owner need not request every cycle.
  - While locked, the other requester receives no grant regardless of round-robin order.
- Simultaneous events: the lock release edge and the other requester's request may coincide. The grant in that cycle is still blocked, because eligibility uses the registered lock_act; the other requester is granted on the next cycle.
- Held requests: a requester not granted keeps rN_req high and its fields stable. Changing fields before grant is legal; the arbiter samples them only in the grant cycle.
- Reset mid-operation: asynchronous assertion clears all state immediately. An in-flight read produces no rvalid, and any lock is dropped.
- Addresses and sizes pass through unchecked; alignment is DataMemory's responsibility.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11;
  - typedef req_id_t (1-bit requester id);
  - localparam NUM_REQ=2.
- One sub-module, rr_picker: takes the eligible vector and rr_last, and produces the one-hot grant combinationally. It is reused by the future instruction-fetch arbiter.

Test Plan:
- Reset, then r0 read addr 0x10 alone (memory word 0x10 = 0xDEADBEEF) -> r0_gnt=1 that cycle, mem_re=1, mem_addr=0x10; next cycle r0_rvalid=1, r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
- r0 and r1 both request in the first cycle after reset -> r0 granted, r1 granted the next cycle; with both held for 4 cycles, grants alternate 0,1,0,1.
- r1 write addr 0x20, wdata 0x000000AB, size 00, then r0 read 0x20 next cycle -> mem_we=1 with size 00 in cycle 1; r0_rdata reflects the byte write; no rvalid for the write.
- r0 read with lock=1 at addr 0x04, r1 requesting continuously, r0 writes 0x04 two cycles later and then drops lock -> r1_gnt=0 until the cycle after lock drops, then r1_gnt=1.
- Back-to-back reads r0@0x08 then r1@0x0C -> r0_rvalid in cycle 2, r1_rvalid in cycle 3, each carrying its own data, never both high.
- rst asserted low asynchronously in the cycle after a read grant -> no rvalid appears; after release, lock_act=0 and r0 wins the first tie.
